// File: rtl/out_uart_defs.sv
`default_nettype none
// ============================================================================
// Module      : out_uart_defs (package)
// Description : Shared definitions for the output-port serialiser:
//               transmitter state encodings, data width, frame lengths and
//               the parity helper.
//               Optional feature macro: OUT_UART_PARITY_EN (adds an even
//               parity bit after the data bits).
// Revision    : 1.0 - initial release
// ============================================================================
package out_uart_defs;

    // Transmitter state encodings
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    // Frame geometry, in bit periods
    localparam int unsigned c_data_bits       = 8;
    localparam int unsigned c_frame_bits_base = 10;  // start + 8 data + stop
    localparam int unsigned c_frame_bits_par  = 11;  // start + 8 data + parity + stop

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : out_fifo
// Description : Synchronous circular-buffer FIFO with show-ahead head output.
//               A push while full is accepted only if a pop happens on the
//               same edge. Pointers wrap modulo DEPTH (power of two).
// Ports       : clk, reset (async, active-low), push, pop, din -> dout (head),
//               full, empty, count
// Revision    : 1.0 - initial release
// ============================================================================
module out_fifo
    import out_uart_defs::*;
#(
    parameter int WIDTH = c_data_bits,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_wr;
    logic w_rd;

    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    assign w_rd = pop && !empty;
    // The slot freed by a same-edge pop makes room for the incoming byte.
    assign w_wr = push && (!full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/out_uart.sv
`default_nettype none
// ============================================================================
// Module      : out_uart
// Description : Output-port serialiser. Bytes strobed by doOut are queued in
//               a FIFO and sent as asynchronous serial frames (start bit,
//               8 data bits LSB first, optional even parity, stop bit).
//               Never stalls the writer; a dropped byte sets sticky overflow.
//               Optional feature macro: OUT_UART_PARITY_EN.
// Ports       : clk, reset (async, active-low), doOut, dbus[7:0]
//               -> tx, busy, full, overflow
// Revision    : 1.0 - initial release
// ============================================================================
module out_uart
    import out_uart_defs::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       doOut,
    input  logic [7:0] dbus,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int              c_cw   = $clog2(CLKS_PER_BIT);
    localparam logic [c_cw-1:0] c_last = c_cw'(CLKS_PER_BIT - 1);

    logic [2:0]              r_state;
    logic [c_cw-1:0]         r_clk_cnt;
    logic [2:0]              r_bit_cnt;
    logic [7:0]              r_shift;
    logic                    r_tx;
    logic                    r_overflow;
`ifdef OUT_UART_PARITY_EN
    logic                    r_parity;
`endif

    logic [7:0]              w_head;
    logic                    w_full;
    logic                    w_empty;
    logic [$clog2(DEPTH):0]  w_count;
    logic                    w_bit_end;
    logic                    w_pop;

    assign w_bit_end = (r_clk_cnt == c_last);
    // Pops only from a registered empty flag, so a byte pushed into an empty
    // FIFO is popped on the following edge, never the same one.
    assign w_pop = !w_empty &&
                   ((r_state == c_st_idle) ||
                    ((r_state == c_st_stop) && w_bit_end));

    out_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (doOut),
        .pop   (w_pop),
        .din   (dbus),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign tx       = r_tx;
    assign busy     = (r_state != c_st_idle) || (w_count != '0);
    assign full     = w_full;
    assign overflow = r_overflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (doOut && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_st_idle;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef OUT_UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            // A pop (from IDLE or at the last STOP cycle) always starts a frame.
            if (w_pop) begin
                r_shift   <= w_head;
`ifdef OUT_UART_PARITY_EN
                r_parity  <= even_parity(w_head);
`endif
                r_bit_cnt <= '0;
                r_clk_cnt <= '0;
                r_state   <= c_st_start;
                r_tx      <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        r_tx      <= 1'b1;
                        r_clk_cnt <= '0;
                    end
                    c_st_start: begin
                        if (w_bit_end) begin
                            r_clk_cnt <= '0;
                            r_state   <= c_st_data;
                            r_tx      <= r_shift[0];
                        end else begin
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                        end
                    end
                    c_st_data: begin
                        if (w_bit_end) begin
                            r_clk_cnt <= '0;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            if (r_bit_cnt == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                                r_state <= c_st_parity;
                                r_tx    <= r_parity;
`else
                                r_state <= c_st_stop;
                                r_tx    <= 1'b1;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                // Next bit is shift[1] before this edge's shift.
                                r_tx      <= r_shift[1];
                            end
                        end else begin
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                        end
                    end
`ifdef OUT_UART_PARITY_EN
                    c_st_parity: begin
                        if (w_bit_end) begin
                            r_clk_cnt <= '0;
                            r_state   <= c_st_stop;
                            r_tx      <= 1'b1;
                        end else begin
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                        end
                    end
`endif
                    c_st_stop: begin
                        // Final cycle with data waiting was handled by the pop.
                        if (w_bit_end) begin
                            r_clk_cnt <= '0;
                            r_state   <= c_st_idle;
                            r_tx      <= 1'b1;
                        end else begin
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= c_st_idle;
                        r_clk_cnt <= '0;
                        r_tx      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
